// File: rtl/la_iodirctl_pkg.sv
// rtl/la_iodirctl_pkg.sv - shared state encoding and counter widths for la_iodirctl
package la_iodirctl_pkg;

  localparam int TURN_CNT_W = 4;
  localparam int HOLD_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  localparam logic [HOLD_CNT_W-1:0] HOLD_SAT = '1;

  // Saturating increment so a long-waiting peer cannot wrap the hold count.
  function automatic logic [HOLD_CNT_W-1:0] sat_inc(input logic [HOLD_CNT_W-1:0] v);
    return (v == HOLD_SAT) ? v : v + HOLD_CNT_W'(1);
  endfunction

endpackage

// File: rtl/la_iodirctl_timer.sv
// rtl/la_iodirctl_timer.sv - loadable down-counter with zero flag for turnaround timing
module la_iodirctl_timer
  import la_iodirctl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [TURN_CNT_W-1:0] load_value,
  input  logic                  en,
  output logic                  zero
);

  logic [TURN_CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - TURN_CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/la_iodirctl.sv
// rtl/la_iodirctl.sv - direction arbiter with dead-time turnaround for a bidirectional link
module la_iodirctl
  import la_iodirctl_pkg::*;
#(
  parameter int TURN    = 2,
  parameter int MAXHOLD = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic a2b,
  output logic turn
);

  localparam logic [TURN_CNT_W-1:0] TURN_LOAD = TURN_CNT_W'(TURN - 1);
  localparam bit                    HOLD_EN   = (MAXHOLD != 0);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LIM  = HOLD_EN ? HOLD_CNT_W'(MAXHOLD - 1) : '0;

  state_t                state_q, state_d;
  logic                  a2b_q, a2b_d;
  logic                  tgt_a_q, tgt_a_d;
  logic                  last_a_q, last_a_d;
  logic [HOLD_CNT_W-1:0] hold_q, hold_d;
  logic                  pick_a;
  logic                  tmr_load;
  logic                  tmr_zero;

  la_iodirctl_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (TURN_LOAD),
    .en         (state_q == ST_TURN),
    .zero       (tmr_zero)
  );

  // last_a resets to 0 (B last owned) so A wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a2b_q    <= 1'b1;
      tgt_a_q  <= 1'b0;
      last_a_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      a2b_q    <= a2b_d;
      tgt_a_q  <= tgt_a_d;
      last_a_q <= last_a_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a2b_d    = a2b_q;
    tgt_a_d  = tgt_a_q;
    last_a_d = last_a_q;
    hold_d   = '0;
    pick_a   = 1'b0;
    tmr_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_a || req_b) begin
          pick_a  = req_a && (!req_b || !last_a_q);
          tgt_a_d = pick_a;
          if (pick_a == a2b_q) begin
            state_d  = pick_a ? ST_OWN_A : ST_OWN_B;
            last_a_d = pick_a;
          end else begin
            state_d  = ST_TURN;
            a2b_d    = ~a2b_q;
            tmr_load = 1'b1;
          end
        end
      end
      ST_OWN_A: begin
        if (!req_a) begin
          state_d = ST_IDLE;
        end else if (req_b && HOLD_EN && (hold_q >= HOLD_LIM)) begin
          state_d  = ST_TURN;
          a2b_d    = 1'b0;
          tgt_a_d  = 1'b0;
          tmr_load = 1'b1;
        end else begin
          hold_d = req_b ? sat_inc(hold_q) : hold_q;
        end
      end
      ST_OWN_B: begin
        if (!req_b) begin
          state_d = ST_IDLE;
        end else if (req_a && HOLD_EN && (hold_q >= HOLD_LIM)) begin
          state_d  = ST_TURN;
          a2b_d    = 1'b1;
          tgt_a_d  = 1'b1;
          tmr_load = 1'b1;
        end else begin
          hold_d = req_a ? sat_inc(hold_q) : hold_q;
        end
      end
      ST_TURN: begin
        // Only the target's request matters; the other side waits for IDLE.
        if (tmr_zero) begin
          if (tgt_a_q ? req_a : req_b) begin
            state_d  = tgt_a_q ? ST_OWN_A : ST_OWN_B;
            last_a_d = tgt_a_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt_a = (state_q == ST_OWN_A);
  assign gnt_b = (state_q == ST_OWN_B);
  assign turn  = (state_q == ST_TURN);
  assign a2b   = a2b_q;

endmodule

// File: tb/tb_la_iodirctl.sv
// tb/tb_la_iodirctl.sv - directed self-checking bench for la_iodirctl (TURN=2, MAXHOLD=8)
module tb_la_iodirctl;

  logic clk;
  logic reset;
  logic req_a;
  logic req_b;
  logic gnt_a;
  logic gnt_b;
  logic a2b;
  logic turn;

  int vectors;
  int miscompares;

  la_iodirctl #(.TURN(2), .MAXHOLD(8)) dut (
    .clk   (clk),
    .reset (reset),
    .req_a (req_a),
    .req_b (req_b),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b),
    .a2b   (a2b),
    .turn  (turn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare {gnt_a, gnt_b, a2b, turn} against a hand-computed vector.
  task automatic chk(input string tag, input logic [3:0] expv);
    logic [3:0] obs;
    obs = {gnt_a, gnt_b, a2b, turn};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed {gnt_a,gnt_b,a2b,turn}=%b expected %b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b1;
    #1;
    chk(tag, 4'b0010);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    #1;
    chk("reset_values", 4'b0010);
    tick();
    chk("reset_held_over_edge", 4'b0010);
    reset = 1'b0;

    // A requests with a2b already pointing A->B: one-cycle grant, no turnaround
    req_a = 1'b1;
    tick(); chk("a_grant_lat1", 4'b1010);
    tick(); chk("a_grant_hold", 4'b1010);
    req_a = 1'b0;
    tick(); chk("a_release", 4'b0010);

    // B from reset: turnaround of 2 cycles then grant
    reset_pulse("reset_before_b");
    req_b = 1'b1;
    tick(); chk("b_turn_c1", 4'b0001);
    tick(); chk("b_turn_c2", 4'b0001);
    tick(); chk("b_grant", 4'b0100);
    req_b = 1'b0;
    tick(); chk("b_release", 4'b0000);

    // Tie after reset goes to A; then handover to B; next tie goes to A again
    reset_pulse("reset_before_tie");
    req_a = 1'b1; req_b = 1'b1;
    tick(); chk("tie1_a_wins", 4'b1010);
    req_a = 1'b0;
    tick(); chk("tie1_a_release_idle", 4'b0010);
    tick(); chk("handover_turn_c1", 4'b0001);
    tick(); chk("handover_turn_c2", 4'b0001);
    tick(); chk("handover_b_grant", 4'b0100);
    req_b = 1'b0;
    tick(); chk("b_release_idle", 4'b0000);
    req_a = 1'b1; req_b = 1'b1;
    tick(); chk("tie2_turn_to_a_c1", 4'b0011);
    tick(); chk("tie2_turn_to_a_c2", 4'b0011);
    tick(); chk("tie2_a_wins", 4'b1010);
    req_a = 1'b0; req_b = 1'b0;
    tick(); chk("tie2_release", 4'b0010);

    // MAXHOLD revoke: A keeps requesting while B waits 8 cycles
    req_a = 1'b1;
    tick(); chk("hold_a_grant", 4'b1010);
    req_b = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(); chk($sformatf("hold_a_kept_%0d", i + 1), 4'b1010);
    end
    tick(); chk("revoke_turn_c1", 4'b0001);
    tick(); chk("revoke_turn_c2", 4'b0001);
    tick(); chk("revoke_b_grant", 4'b0100);
    req_a = 1'b0; req_b = 1'b0;
    tick(); chk("revoke_release", 4'b0000);

    // B abandons its request during TURN: end in IDLE with a2b=0
    reset_pulse("reset_before_abandon");
    req_b = 1'b1;
    tick(); chk("abandon_turn_c1", 4'b0001);
    req_b = 1'b0;
    tick(); chk("abandon_turn_c2", 4'b0001);
    tick(); chk("abandon_idle", 4'b0000);
    tick(); chk("abandon_idle_stays", 4'b0000);

    // Asynchronous reset in the middle of TURN and of OWN_B
    reset_pulse("reset_before_async");
    req_b = 1'b1;
    tick(); chk("async_turn_entered", 4'b0001);
    reset_pulse("async_reset_mid_turn");
    tick(); chk("retry_turn_c1", 4'b0001);
    tick(); chk("retry_turn_c2", 4'b0001);
    tick(); chk("retry_b_grant", 4'b0100);
    tick(); chk("retry_b_hold", 4'b0100);
    reset_pulse("async_reset_mid_own_b");
    req_b = 1'b0;
    tick(); chk("post_reset_idle", 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
